ibex_multdiv_issue: RTL

//  Requester/host side of the ibex_multdiv_fast interface, i.e. the ID/EX-side partner of the multiplier/divider.
//  - Accepts one M-extension op over a valid/ready request port and drives the multdiv enables, selects and operands.
//  - Supplies the ALU adder path, the equal-to-zero flag and the two 34-bit intermediate-value registers.
//  - Captures the result on valid and returns it over a valid/ready response port with a latency count.

---
 rtl/ibex_multdiv_issue.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/ibex_multdiv_issue.sv
// Issue-side partner of ibex_multdiv_fast: takes one M-extension op over valid/ready,
// drives the multdiv enables/operands, provides adder/imd storage and returns the result.
module ibex_multdiv_issue #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // request port
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        req_op_i,
  input  logic [1:0]        req_signed_mode_i,
  input  logic [31:0]       req_a_i,
  input  logic [31:0]       req_b_i,
  // response port
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_result_o,
  output logic              rsp_err_o,
  output logic [CNT_W-1:0]  rsp_cycles_o,
  // multdiv control
  output logic              mult_en_o,
  output logic              div_en_o,
  output logic              mult_sel_o,
  output logic              div_sel_o,
  output logic [1:0]        operator_o,
  output logic [1:0]        signed_mode_o,
  output logic [31:0]       op_a_o,
  output logic [31:0]       op_b_o,
  output logic              multdiv_ready_id_o,
  input  logic              valid_i,
  input  logic [31:0]       multdiv_result_i,
  // adder / zero flag
  input  logic [32:0]       alu_operand_a_i,
  input  logic [32:0]       alu_operand_b_i,
  output logic [33:0]       alu_adder_ext_o,
  output logic [31:0]       alu_adder_o,
  output logic              equal_to_zero_o,
  // intermediate-value registers
  input  logic [33:0]       imd_val_d_i [2],
  input  logic [1:0]        imd_val_we_i,
  output logic [33:0]       imd_val_q_o [2]
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  localparam int unsigned       CNT_LIM = (1 << CNT_W) - 1;
  // Reported cycle count on timeout, clipped to what the counter can show.
  localparam logic [CNT_W-1:0]  TO_CNT  = (TIMEOUT_CYCLES > CNT_LIM) ? {CNT_W{1'b1}}
                                                                     : CNT_W'(TIMEOUT_CYCLES);

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W:0]     cnt_inc;
  logic [CNT_W-1:0]   cnt_sat;
  logic               timeout_hit;
  logic               mult_en;
  logic               div_en;

  assign cnt_inc     = {1'b0, cnt} + 1'b1;
  assign cnt_sat     = (&cnt) ? cnt : cnt_inc[CNT_W-1:0];
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (32'(cnt_inc) == TIMEOUT_CYCLES);

  assign req_ready_o = (state == IDLE);
  assign mult_en_o   = mult_en;
  assign mult_sel_o  = mult_en;
  assign div_en_o    = div_en;
  assign div_sel_o   = div_en;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state              <= IDLE;
      cnt                <= '0;
      mult_en            <= 1'b0;
      div_en             <= 1'b0;
      multdiv_ready_id_o <= 1'b0;
      operator_o         <= '0;
      signed_mode_o      <= '0;
      op_a_o             <= '0;
      op_b_o             <= '0;
      rsp_valid_o        <= 1'b0;
      rsp_result_o       <= '0;
      rsp_err_o          <= 1'b0;
      rsp_cycles_o       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid_i) begin
            operator_o         <= req_op_i;
            signed_mode_o      <= req_signed_mode_i;
            op_a_o             <= req_a_i;
            op_b_o             <= req_b_i;
            cnt                <= '0;
            mult_en            <= ~req_op_i[1];
            div_en             <= req_op_i[1];
            multdiv_ready_id_o <= 1'b1;
            state              <= BUSY;
          end
        end
        BUSY: begin
          // A result arriving on the timeout cycle takes priority over the abort.
          if (valid_i || timeout_hit) begin
            rsp_result_o       <= valid_i ? multdiv_result_i : 32'd0;
            rsp_err_o          <= ~valid_i;
            rsp_cycles_o       <= valid_i ? cnt_sat : TO_CNT;
            rsp_valid_o        <= 1'b1;
            mult_en            <= 1'b0;
            div_en             <= 1'b0;
            multdiv_ready_id_o <= 1'b0;
            state              <= RESP;
          end else begin
            cnt <= cnt_sat;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      imd_val_q_o[0] <= '0;
      imd_val_q_o[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (imd_val_we_i[i]) imd_val_q_o[i] <= imd_val_d_i[i];
      end
    end
  end

  assign alu_adder_ext_o = {1'b0, alu_operand_a_i} + {1'b0, alu_operand_b_i};
  assign alu_adder_o     = alu_adder_ext_o[32:1];
  assign equal_to_zero_o = (op_b_o == 32'd0);

endmodule
